run_controller: RTL

- Top-level run FSM that sits between the testbench start/done handshake and the single-cycle core (program_counter, register_file, data_memory).
- Sequences each program run in four steps: clear core state, wait for start release, run, report done.
- Walks a zeroing write through data_memory before every run.
- Counts executed cycles for performance reporting.

---
 rtl/run_controller_if.sv | 51 +++++
 rtl/run_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/run_controller_if.sv
// -----------------------------------------------------------------------------
// run_controller_if
//   Groups the run handshake and core-control signals of run_controller.
//
//   Parameters:
//     ADDR_W : width of the data_memory zeroing address
//     CNT_W  : width of the run cycle counter
//
//   Signals:
//     start       : start request from the testbench
//     core_done   : done decode from control_decoder
//     core_clear  : synchronous clear to program_counter/register_file
//     run_en      : enables PC advance and register/memory writes
//     clr_we      : data_memory zeroing write strobe
//     clr_addr    : data_memory zeroing address
//     done        : run-complete flag
//     timeout     : run ended by the cycle limit
//     cycle_count : RUN cycles in the current or last run
//     state       : encoded FSM state for debug
//
//   Modports:
//     master : the controller (drives everything except start/core_done)
//     slave  : the environment (drives start/core_done)
// -----------------------------------------------------------------------------
interface run_controller_if #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) ();

   logic              start;
   logic              core_done;
   logic              core_clear;
   logic              run_en;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              done;
   logic              timeout;
   logic [CNT_W-1:0]  cycle_count;
   logic [2:0]        state;

   modport master (
      input  start, core_done,
      output core_clear, run_en, clr_we, clr_addr, done, timeout, cycle_count, state
   );

   modport slave (
      output start, core_done,
      input  core_clear, run_en, clr_we, clr_addr, done, timeout, cycle_count, state
   );

endinterface

// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
//   Run FSM between the start/done handshake and the single-cycle core.
//   Each run: zero data_memory while holding the core in clear (CLEAR),
//   wait for start to be released (HOLD), execute (RUN), report (FIN).
//   Executed RUN cycles are counted, saturating at all-ones.
//
//   Optional feature (macro RUN_TIMEOUT_EN):
//     defined   : RUN ends with timeout=1 once MAX_CYCLES cycles have run
//                 without core_done; core_done on that cycle wins.
//     undefined : timeout is tied to 0, RUN waits indefinitely.
//
//   Ports:
//     clk   : system clock
//     reset : asynchronous, active-high reset
//     bus   : run_controller_if.master (start, core_done in; core_clear,
//             run_en, clr_we, clr_addr, done, timeout, cycle_count, state out)
//
//   All outputs are registers or decodes of the state register only.
// -----------------------------------------------------------------------------
module run_controller #(
   parameter int ADDR_W      = 8,
   parameter int CLEAR_DEPTH = 256,
   parameter int CNT_W       = 16,
   parameter int MAX_CYCLES  = 4096
) (
   input  logic               clk,
   input  logic               reset,
   run_controller_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      HOLD  = 3'd2,
      RUN   = 3'd3,
      FIN   = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_SAT  = '1;

`ifdef RUN_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] clr_addr_q;
   logic [CNT_W-1:0]  cycle_count_q;
   logic              clr_last;
   logic              limit_hit;
   logic              enter_clear;
   logic              core_clear_d;
   logic              run_en_d;
   logic              clr_we_d;
   logic              done_d;

   assign clr_last    = (clr_addr_q == CLR_LAST);
   // The current RUN cycle is the MAX_CYCLES-th one when the count of
   // already-completed cycles is MAX_CYCLES-1.
   assign limit_hit   = TIMEOUT_EN && (cycle_count_q >= CNT_LAST);
   assign enter_clear = (state_d == CLEAR) && (state_q != CLEAR);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first so no path
   // leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_d      = state_q;
      core_clear_d = 1'b0;
      run_en_d     = 1'b0;
      clr_we_d     = 1'b0;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = CLEAR;
         end
         CLEAR: begin
            core_clear_d = 1'b1;
            clr_we_d     = 1'b1;
            if (clr_last) state_d = HOLD;
         end
         HOLD: begin
            // core_done is ignored: fetch at PC 0 may decode stale here.
            core_clear_d = 1'b1;
            if (!bus.start) state_d = RUN;
         end
         RUN: begin
            run_en_d = 1'b1;
            if (bus.core_done || limit_hit) state_d = FIN;
         end
         FIN: begin
            done_d = 1'b1;
            if (bus.start) state_d = CLEAR;
         end
         default: state_d = IDLE;
      endcase
   end

   // Zeroing address walks 0..CLEAR_DEPTH-1 in CLEAR and rests at 0 elsewhere,
   // so it is already 0 on the first CLEAR cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           clr_addr_q <= '0;
      else if (state_q == CLEAR && !clr_last) clr_addr_q <= clr_addr_q + ADDR_W'(1);
      else                                 clr_addr_q <= '0;
   end

   // The cycle that samples core_done is still counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cycle_count_q <= '0;
      else if (enter_clear)
         cycle_count_q <= '0;
      else if (state_q == RUN && cycle_count_q != CNT_SAT)
         cycle_count_q <= cycle_count_q + CNT_W'(1);
   end

`ifdef RUN_TIMEOUT_EN
   logic timeout_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timeout_q <= 1'b0;
      else if (enter_clear)
         timeout_q <= 1'b0;
      else if (state_q == RUN && limit_hit && !bus.core_done)
         timeout_q <= 1'b1;
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.core_clear  = core_clear_d;
   assign bus.run_en      = run_en_d;
   assign bus.clr_we      = clr_we_d;
   assign bus.clr_addr    = clr_addr_q;
   assign bus.done        = done_d;
   assign bus.cycle_count = cycle_count_q;
   assign bus.state       = state_q;

endmodule
